// File: rtl/morse_pkg.sv
// Shared Morse opcode constants, character code record and encoder state type.
// The sequencer imports the same opcode constants so both ends agree on the encoding.
package morse_pkg;

  localparam logic [7:0] OP_SPC = 8'h00;
  localparam logic [7:0] OP_DIT = 8'h80;
  localparam logic [7:0] OP_DAH = 8'h40;

  // Element pattern is left-justified: pat[4] is the first element, 1 = dah.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } morse_code_t;

  typedef enum logic [1:0] {
    IDLE,
    ELEM,
    ISPC,
    GAP
  } state_t;

  // Builds a code from a right-justified element list, as the table reads naturally.
  function automatic morse_code_t mk_code(input logic [2:0] len, input logic [4:0] bits);
    morse_code_t c;
    c.len = len;
    c.pat = bits << (3'd5 - len);
    return c;
  endfunction

  function automatic logic [7:0] elem_op(input logic is_dah);
    return is_dah ? OP_DAH : OP_DIT;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII to Morse lookup: letters (either case), digits and space.
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0]  char_data,
  output logic        supported,
  output logic        is_space,
  output morse_code_t code
);

  logic [7:0] upper;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    supported = 1'b1;
    is_space  = 1'b0;
    code      = '0;
    upper     = char_data;
    if (char_data >= 8'h61 && char_data <= 8'h7A) upper = char_data & 8'hDF;

    case (upper)
      8'h20: is_space = 1'b1;
      "A": code = mk_code(3'd2, 5'b00001);
      "B": code = mk_code(3'd4, 5'b01000);
      "C": code = mk_code(3'd4, 5'b01010);
      "D": code = mk_code(3'd3, 5'b00100);
      "E": code = mk_code(3'd1, 5'b00000);
      "F": code = mk_code(3'd4, 5'b00010);
      "G": code = mk_code(3'd3, 5'b00110);
      "H": code = mk_code(3'd4, 5'b00000);
      "I": code = mk_code(3'd2, 5'b00000);
      "J": code = mk_code(3'd4, 5'b00111);
      "K": code = mk_code(3'd3, 5'b00101);
      "L": code = mk_code(3'd4, 5'b00100);
      "M": code = mk_code(3'd2, 5'b00011);
      "N": code = mk_code(3'd2, 5'b00010);
      "O": code = mk_code(3'd3, 5'b00111);
      "P": code = mk_code(3'd4, 5'b00110);
      "Q": code = mk_code(3'd4, 5'b01101);
      "R": code = mk_code(3'd3, 5'b00010);
      "S": code = mk_code(3'd3, 5'b00000);
      "T": code = mk_code(3'd1, 5'b00001);
      "U": code = mk_code(3'd3, 5'b00001);
      "V": code = mk_code(3'd4, 5'b00001);
      "W": code = mk_code(3'd3, 5'b00011);
      "X": code = mk_code(3'd4, 5'b01001);
      "Y": code = mk_code(3'd4, 5'b01011);
      "Z": code = mk_code(3'd4, 5'b01100);
      "0": code = mk_code(3'd5, 5'b11111);
      "1": code = mk_code(3'd5, 5'b01111);
      "2": code = mk_code(3'd5, 5'b00111);
      "3": code = mk_code(3'd5, 5'b00011);
      "4": code = mk_code(3'd5, 5'b00001);
      "5": code = mk_code(3'd5, 5'b00000);
      "6": code = mk_code(3'd5, 5'b10000);
      "7": code = mk_code(3'd5, 5'b11000);
      "8": code = mk_code(3'd5, 5'b11100);
      "9": code = mk_code(3'd5, 5'b11110);
      default: supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_char_encoder.sv
// Expands accepted ASCII characters into a dit/dah/spc opcode stream with element,
// letter and word gaps, over valid/ready handshakes on both sides.
module morse_char_encoder
  import morse_pkg::*;
#(
  parameter int unsigned LETTER_GAP     = 3,
  parameter int unsigned WORD_GAP_EXTRA = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] op_data,
  output logic       op_valid,
  input  logic       op_ready,
  output logic       char_err
);

  localparam logic [3:0] LETTER_CNT = 4'(LETTER_GAP);
  localparam logic [3:0] WORD_CNT   = 4'(WORD_GAP_EXTRA);

  state_t      state, state_n;
  morse_code_t code_q, code_n;
  logic [2:0]  idx, idx_n;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  op_data_n;
  logic        op_valid_n;
  logic        char_err_n;

  logic        lut_supported;
  logic        lut_is_space;
  morse_code_t lut_code;
  logic        accept;
  logic        op_xfer;

  morse_lut u_lut (
    .char_data (char_data),
    .supported (lut_supported),
    .is_space  (lut_is_space),
    .code      (lut_code)
  );

  assign char_ready = (state == IDLE) && !rst;
  assign accept     = char_valid && char_ready;
  assign op_xfer    = op_valid && op_ready;

  always_comb begin
    state_n    = state;
    code_n     = code_q;
    idx_n      = idx;
    cnt_n      = cnt;
    char_err_n = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (lut_is_space) begin
            cnt_n = WORD_CNT;
            if (WORD_GAP_EXTRA != 0) state_n = GAP;
          end else if (lut_supported) begin
            code_n  = lut_code;
            idx_n   = 3'd0;
            state_n = ELEM;
          end else begin
            char_err_n = 1'b1;
          end
        end
      end
      ELEM: begin
        if (op_xfer) begin
          if ((idx + 3'd1) < code_q.len) begin
            state_n = ISPC;
          end else begin
            cnt_n   = LETTER_CNT;
            state_n = (LETTER_GAP != 0) ? GAP : IDLE;
          end
        end
      end
      ISPC: begin
        if (op_xfer) begin
          idx_n   = idx + 3'd1;
          state_n = ELEM;
        end
      end
      GAP: begin
        if (op_xfer) begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are computed from the next state so they can be registered without a lag cycle.
    op_valid_n = (state_n != IDLE);
    op_data_n  = (state_n == ELEM) ? elem_op(code_n.pat[3'd4 - idx_n]) : OP_SPC;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: async reset clears all control and output registers; the latched code is cleared too, it is tiny.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      code_q   <= '0;
      idx      <= 3'd0;
      cnt      <= 4'd0;
      op_data  <= OP_SPC;
      op_valid <= 1'b0;
      char_err <= 1'b0;
    end else begin
      state    <= state_n;
      code_q   <= code_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      op_data  <= op_data_n;
      op_valid <= op_valid_n;
      char_err <= char_err_n;
    end
  end

endmodule

// File: tb/tb_morse_char_encoder.sv
// Self-checking bench: directed scenarios plus random characters against a string-table Morse model.
module tb_morse_char_encoder;

  localparam int LG = 3;
  localparam int WG = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] op_data;
  logic       op_valid;
  logic       op_ready;
  logic       char_err;

  int checks = 0;
  int errors = 0;
  byte unsigned exp_q[$];

  string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                         ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                         "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits[10] = '{"-----", ".----", "..---", "...--", "....-",
                        ".....", "-....", "--...", "---..", "----."};

  morse_char_encoder #(.LETTER_GAP(LG), .WORD_GAP_EXTRA(WG)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .op_data    (op_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .char_err   (char_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Appends the expected opcode stream for c to exp_q; returns 0 for unsupported codes.
  function automatic bit model(input byte unsigned c);
    string s;
    byte unsigned u = c;
    if (u >= "a" && u <= "z") u = u - 8'd32;
    if (u == 8'h20) begin
      repeat (WG) exp_q.push_back(8'h00);
      return 1'b1;
    end
    if (u >= "A" && u <= "Z") s = letters[u - "A"];
    else if (u >= "0" && u <= "9") s = digits[u - "0"];
    else return 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) exp_q.push_back(8'h00);
      exp_q.push_back((s[i] == "-") ? 8'h40 : 8'h80);
    end
    repeat (LG) exp_q.push_back(8'h00);
    return 1'b1;
  endfunction

  // mode 0: op_ready always 1; 1: random back-pressure; 2: 5-cycle stall on first two opcodes.
  task automatic send_char(input byte unsigned c, input int mode);
    bit         ok;
    bit         r;
    bit         held = 1'b0;
    logic [7:0] held_val = 8'h00;
    int         wait_n = 0;
    int         k = 0;
    int         stall_left;
    int         budget = 500;
    while (!char_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("char_ready_before_send", char_ready, 1);
    exp_q.delete();
    ok = model(c);
    char_data  = c;
    char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    char_data  = 8'($urandom);
    check("char_err_pulse", char_err, !ok);
    if (!ok) begin
      check("err_no_op_valid", op_valid, 0);
      @(negedge clk);
      check("err_one_cycle", char_err, 0);
      check("err_ready_again", char_ready, 1);
      check("err_still_no_op", op_valid, 0);
      return;
    end
    stall_left = (mode == 2) ? 5 : 0;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) != 0);
        default: begin
          r = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      op_ready = r;
      check("op_valid_busy", op_valid, 1);
      if (held) check("op_data_held", op_data, held_val);
      if (r) begin
        check("op_data", op_data, exp_q.pop_front());
        k++;
        held = 1'b0;
        if (mode == 2 && k == 1) stall_left = 5;
      end else begin
        held     = 1'b1;
        held_val = op_data;
      end
      @(negedge clk);
    end
    check("sequence_complete", exp_q.size(), 0);
    check("idle_op_valid", op_valid, 0);
    check("idle_op_data", op_data, 8'h00);
    check("idle_char_ready", char_ready, 1);
    check("idle_char_err", char_err, 0);
    op_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned c;
    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    op_ready   = 1'b1;
    #1;
    check("reset_char_ready", char_ready, 0);
    check("reset_op_valid", op_valid, 0);
    check("reset_op_data", op_data, 8'h00);
    check("reset_char_err", char_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_ready", char_ready, 1);

    // Reset pulse while idle, then 'E'.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #2;
    check("idle_rst_ready_low", char_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_rst_ready_back", char_ready, 1);
    @(negedge clk);
    send_char(8'h45, 0);

    send_char(8'h61, 0);
    send_char(8'h41, 0);
    send_char(8'h30, 0);
    send_char(8'h20, 0);
    send_char(8'h3F, 0);
    send_char(8'h4B, 0);
    send_char(8'h4B, 2);

    // Reset in the middle of 'O', after its second dah has been transferred.
    exp_q.delete();
    void'(model(8'h4F));
    op_ready   = 1'b1;
    char_data  = 8'h4F;
    char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("o_op_valid", op_valid, 1);
      check("o_op_data", op_data, exp_q.pop_front());
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("o_rst_op_valid", op_valid, 0);
    check("o_rst_op_data", op_data, 8'h00);
    check("o_rst_char_ready", char_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("o_no_residual", op_valid, 0);
      check("o_idle_ready", char_ready, 1);
    end
    send_char(8'h54, 0);

    // Random characters with random back-pressure.
    repeat (40) begin
      case ($urandom_range(0, 3))
        0:       c = 8'($urandom);
        1:       c = 8'($urandom_range(0, 25) + ($urandom_range(0, 1) ? 8'h41 : 8'h61));
        2:       c = 8'($urandom_range(0, 9) + 8'h30);
        default: c = 8'h20;
      endcase
      send_char(c, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
